uart_ctrl: RTL and testbench
============================

# uart_ctrl

Parametrised Wishbone-slave UART that replaces the fixed 8N1 UART in the SoC peripheral space. It uses one clock domain, a programmable 16x-oversampling baud divider, and TX/RX FIFOs of configurable depth. Parity mode and stop-bit count are selected at run time. A status register exposes FIFO levels and sticky error flags, and a maskable interrupt output is provided.

## Interface
- DIV_RESET, 78: reset value of the baud divider (12 MHz / (16 × 78) ≈ 9600 baud)
- DIV_WIDTH, 16: divider register width, in bits
- FIFO_DEPTH, 16: entries per FIFO; must be a power of two and ≥ 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; all state is cleared on the next clk edge
- rx_bit  in  1  serial input, asynchronous; idle level 1
- tx_bit  out  1  serial output; idle level 1
- wb_addr  in  3  register select
- wb_data_in  in  8  write data
- wb_data_out  out  8  read data, valid while wb_ack = 1
- wb_we  in  1  1 = write, 0 = read
- wb_stb  in  1  access request
- wb_ack  out  1  single-cycle acknowledge
- irq  out  1  level interrupt

## Operation
- Register map:
  - 0 TX: write pushes a byte; a write while the TX FIFO is full is dropped.
  - 1 RX: read pops a byte; a read while empty returns 0x00 with no pop.
  - 2 DIV_LO, 3 DIV_HI: divider bits [7:0] and [DIV_WIDTH-1:8].
  - 4 CTRL: [1:0] parity (00 none, 01 even, 10 odd, 11 none); [2] two stop bits; [3] rx_ie; [4] tx_ie.
  - 5 STATUS: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] frame_err, [5] parity_err, [6] overrun, [7] tx_busy. Writing 1 to bits 4–6 clears them.
  - Addresses 6–7: reads return 0x00; writes are ignored.
- Baud tick: a counter runs 0..div-1 and emits a one-cycle tick at div-1. A divider value of 0 behaves as 1. Any write to DIV_LO or DIV_HI clears the counter.
- One bit period is 16 ticks.
- TX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
  - Leaves IDLE on the first tick with the TX FIFO non-empty, popping the byte in the same cycle.
  - Data is sent LSB first, 8 bits.
  - PARITY is skipped when parity is none.
  - STOP lasts 16 or 32 ticks.
  - tx_busy = (state ≠ IDLE).
- RX path: rx_bit passes through a 2-flop synchroniser first.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
  - IDLE: detects a low level on a tick.
  - START: at tick 8 re-samples the line. If it is high (false start), return to IDLE with no push and no flag.
  - DATA, PARITY, STOP: each bit is sampled 16 ticks after the previous sample, i.e. at mid-bit.
  - Only the first stop bit is checked.
- End of frame:
  - Stop sample = 0 sets frame_err.
  - Parity mismatch sets parity_err.
  - The byte is pushed even when it carries an error.
  - If the RX FIFO is full, the byte is discarded and overrun is set.
- irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty & !tx_busy).
- CTRL changes take effect at the next frame start; a frame in flight keeps its settings.

## Timing
- Reset values:
  - Outputs: tx_bit = 1, wb_ack = 0, wb_data_out = 0x00, irq = 0.
  - Registers: divider = DIV_RESET, CTRL = 0x00, both FIFOs empty, sticky flags = 0, both FSMs in IDLE.
- Reset mid-frame aborts the frame. tx_bit is 1 from the cycle after the reset edge.
- Bus handshake:
  - An access is accepted when wb_stb = 1 and wb_ack = 0.
  - wb_ack = 1 in exactly the following cycle, for exactly one cycle; wb_data_out is valid in that cycle.
  - The FIFO push or pop and the register write occur in the acceptance cycle.
  - Maximum throughput is one access per 2 cycles.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap, with a count register of width log2(FIFO_DEPTH)+1.
  - A push and a pop in the same cycle on a non-empty FIFO are both performed; the count is unchanged.
  - A push and a pop in the same cycle on an empty FIFO: the pop returns 0x00 and the push is performed.
  - A push when full is ignored, even if a pop occurs in the same cycle.
- TX latency: with the FSM idle and the FIFO empty, a write drives tx_bit low within div+1 cycles of the acceptance cycle.
- RX latency: the byte appears in the RX FIFO 1 cycle after the tick that samples the stop bit.
- Sticky-flag collision: if a W1C write and a set event occur in the same cycle, the set wins.

## Test plan
- Reset, then read STATUS and DIV_LO -> STATUS = 0x06 (tx_empty, rx_empty); DIV_LO = 0x4E; tx_bit = 1.
- Set DIV = 1, parity none, write 0xA5 -> tx_bit shows start bit, then LSB-first data 1,0,1,0,0,1,0,1, then stop bit; each bit lasts 16 clk; tx_busy falls after the stop bit.
- TX looped back to RX, DIV = 1, even parity, two stop bits, send 0x3C -> RX reads 0x3C, STATUS[5:4] = 00, parity bit on the line = 0.
- Drive a frame with stop bit = 0 and data 0x55 -> RX reads 0x55, frame_err = 1; writing 0x10 to STATUS clears it.
- Send FIFO_DEPTH+1 frames without reading RX -> first FIFO_DEPTH bytes are intact, overrun = 1, rx_full = 1.
- Drive a 4-tick low glitch on rx_bit -> no push, no flags; irq stays 0 with rx_ie = 1.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: Wishbone-slave UART with a programmable 16x-oversampling baud
// divider, TX/RX FIFOs, run-time parity / stop-bit selection, sticky error
// flags and a maskable level interrupt. Single clock domain.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rx_bit            serial input (asynchronous, idle 1)
//   tx_bit            serial output (idle 1, registered)
//   wb_addr           register select (0 TX, 1 RX, 2 DIV_LO, 3 DIV_HI,
//                     4 CTRL, 5 STATUS, 6-7 reserved)
//   wb_data_in        write data
//   wb_data_out       read data, valid while wb_ack = 1 (0x00 otherwise)
//   wb_we, wb_stb     write enable / access request
//   wb_ack            single-cycle acknowledge
//   irq               level interrupt
//
// DIV_WIDTH is expected to be in the range 9..16 so DIV_HI maps onto one byte.

module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push on a full FIFO is dropped even when a pop happens in the same
  // cycle; a pop on an empty FIFO is a no-op and reads as 0x00.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_ctrl #(
  parameter int DIV_RESET  = 78,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  output logic       tx_bit,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } uart_state_t;

  // Bus handshake: wb_stb is the request (valid), !wb_ack is the ready.
  // A request is accepted in a cycle where wb_stb = 1 and wb_ack = 0; all
  // side effects (register write, FIFO push/pop) happen in that cycle and
  // wb_ack / wb_data_out are presented for exactly the following cycle.
  logic accept;
  assign accept = wb_stb & ~wb_ack;

  logic [DIV_WIDTH-1:0] div_q, baud_cnt, div_eff;
  logic [4:0]           ctrl_q;
  logic                 frame_err, parity_err, overrun;
  logic                 tick, div_wr;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_rdata;

  uart_state_t tx_state, rx_state;
  logic        tx_busy;
  logic [4:0]  tx_tcnt;
  logic [2:0]  tx_bidx;
  logic [7:0]  tx_shreg;
  logic        tx_par_bit, tx_par_en, tx_two_stop;

  logic [1:0]  rx_sync;
  logic        rx_s;
  logic [3:0]  rx_tcnt;
  logic [2:0]  rx_bidx;
  logic [7:0]  rx_shreg;
  logic        rx_par_en, rx_par_odd, rx_par_bad;

  logic [7:0]  status, rd_mux;

  // ---------------- baud tick ----------------
  assign div_eff = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign tick    = (baud_cnt == div_eff - DIV_WIDTH'(1));
  assign div_wr  = accept & wb_we & ((wb_addr == 3'd2) | (wb_addr == 3'd3));

  always_ff @(posedge clk) begin
    if (reset || div_wr) baud_cnt <= '0;
    else if (tick)       baud_cnt <= '0;
    else                 baud_cnt <= baud_cnt + DIV_WIDTH'(1);
  end

  // ---------------- FIFOs ----------------
  assign tx_push = accept & wb_we & (wb_addr == 3'd0);
  assign tx_pop  = (tx_state == S_IDLE) & tick & ~tx_empty;
  assign rx_pop  = accept & ~wb_we & (wb_addr == 3'd1);
  assign rx_push = (rx_state == S_STOP) & tick & (rx_tcnt == 4'd15);

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(wb_data_in),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_shreg),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- register file / bus ----------------
  assign tx_busy = (tx_state != S_IDLE);
  assign status  = {tx_busy, overrun, parity_err, frame_err,
                    rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    rd_mux = 8'h00;
    case (wb_addr)
      3'd1:    rd_mux = rx_rdata;
      3'd2:    rd_mux = div_q[7:0];
      3'd3:    rd_mux = 8'(div_q >> 8);
      3'd4:    rd_mux = {3'b000, ctrl_q};
      3'd5:    rd_mux = status;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack      <= 1'b0;
      wb_data_out <= 8'h00;
      div_q       <= DIV_WIDTH'(DIV_RESET);
      ctrl_q      <= 5'd0;
    end else begin
      wb_ack      <= accept;
      wb_data_out <= (accept & ~wb_we) ? rd_mux : 8'h00;
      if (accept & wb_we) begin
        case (wb_addr)
          3'd2:    div_q[7:0]           <= wb_data_in;
          3'd3:    div_q[DIV_WIDTH-1:8] <= wb_data_in[DIV_WIDTH-9:0];
          3'd4:    ctrl_q               <= wb_data_in[4:0];
          default: ;
        endcase
      end
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C write wins.
  logic w1c;
  assign w1c = accept & wb_we & (wb_addr == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (frame_err  & ~(w1c & wb_data_in[4])) | (rx_push & ~rx_s);
      parity_err <= (parity_err & ~(w1c & wb_data_in[5])) | (rx_push & rx_par_bad);
      overrun    <= (overrun    & ~(w1c & wb_data_in[6])) | (rx_push & rx_full);
    end
  end

  assign irq = (ctrl_q[3] & ~rx_empty) | (ctrl_q[4] & tx_empty & ~tx_busy);

  // ---------------- TX FSM ----------------
  // Frame settings are captured when the byte is popped so CTRL writes
  // during a frame only affect the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= S_IDLE;
      tx_bit      <= 1'b1;
      tx_tcnt     <= 5'd0;
      tx_bidx     <= 3'd0;
      tx_shreg    <= 8'h00;
      tx_par_bit  <= 1'b0;
      tx_par_en   <= 1'b0;
      tx_two_stop <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_bit <= 1'b1;
          if (tx_pop) begin
            tx_shreg    <= tx_rdata;
            tx_par_bit  <= ctrl_q[1] ? ~^tx_rdata : ^tx_rdata;
            tx_par_en   <= ^ctrl_q[1:0];
            tx_two_stop <= ctrl_q[2];
            tx_tcnt     <= 5'd0;
            tx_bit      <= 1'b0;
            tx_state    <= S_START;
          end
        end
        S_START: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt  <= 5'd0;
            tx_bidx  <= 3'd0;
            tx_bit   <= tx_shreg[0];
            tx_state <= S_DATA;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        S_DATA: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt <= 5'd0;
            if (tx_bidx == 3'd7) begin
              if (tx_par_en) begin
                tx_bit   <= tx_par_bit;
                tx_state <= S_PARITY;
              end else begin
                tx_bit   <= 1'b1;
                tx_state <= S_STOP;
              end
            end else begin
              tx_bidx  <= tx_bidx + 3'd1;
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_bit   <= tx_shreg[1];
            end
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        S_PARITY: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt  <= 5'd0;
            tx_bit   <= 1'b1;
            tx_state <= S_STOP;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        S_STOP: if (tick) begin
          if (tx_tcnt == (tx_two_stop ? 5'd31 : 5'd15)) begin
            tx_tcnt  <= 5'd0;
            tx_state <= S_IDLE;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        default: begin
          tx_bit   <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  always_ff @(posedge clk) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx_bit};
  end
  assign rx_s = rx_sync[1];

  // Start is confirmed 8 ticks after detection (mid start bit); every later
  // sample is 16 ticks after the previous one. Only the first stop bit is
  // sampled, after which the FSM is ready for the next start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= S_IDLE;
      rx_tcnt    <= 4'd0;
      rx_bidx    <= 3'd0;
      rx_shreg   <= 8'h00;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bad <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: if (tick && !rx_s) begin
          rx_tcnt    <= 4'd0;
          rx_par_en  <= ^ctrl_q[1:0];
          rx_par_odd <= ctrl_q[1];
          rx_par_bad <= 1'b0;
          rx_state   <= S_START;
        end
        S_START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt  <= 4'd0;
            rx_bidx  <= 3'd0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else rx_tcnt <= rx_tcnt + 4'd1;
        end
        S_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            if (rx_bidx == 3'd7) rx_state <= rx_par_en ? S_PARITY : S_STOP;
            else                 rx_bidx  <= rx_bidx + 3'd1;
          end
        end
        S_PARITY: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_par_bad <= rx_s != (rx_par_odd ? ~^rx_shreg : ^rx_shreg);
            rx_state   <= S_STOP;
          end
        end
        S_STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed testbench for uart_ctrl: register access, TX framing, loopback
// with parity / stop options, RX error flags, overrun, glitch rejection,
// interrupt and reset behaviour.
module tb_uart_ctrl;
  localparam int FIFO_DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_bit, tx_bit, wb_ack, irq;
  logic [2:0] wb_addr = 3'd0;
  logic [7:0] wb_data_in = 8'h00, wb_data_out;
  logic       wb_we = 1'b0, wb_stb = 1'b0;

  int tests = 0;
  int fails = 0;

  assign rx_bit = loop_en ? tx_bit : rx_drv;

  uart_ctrl #(.DIV_RESET(78), .DIV_WIDTH(16), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_bit(rx_bit), .tx_bit(tx_bit),
    .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack), .irq(irq)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Both bus tasks return on the posedge that ends the ack cycle.
  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_data_in = d;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
    @(posedge clk); #1;
    d = wb_data_out;
    wb_stb = 1'b0;
    @(posedge clk);
  endtask

  task automatic set_div(input logic [15:0] d);
    wb_write(3'd2, d[7:0]);
    wb_write(3'd3, d[15:8]);
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (16) @(negedge clk);
  endtask

  // Serial frame at 16 clk per bit (divider 1), followed by one idle bit.
  task automatic send_rx(input logic [7:0] d, input logic par_en,
                         input logic par_b, input logic stop_b);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_b);
    drive_bit(stop_b);
    drive_bit(1'b1);
  endtask

  // Leaves the caller 1 time unit after the edge that drove tx_bit low.
  task automatic wait_tx_fall(output logic found);
    found = 1'b0;
    #1;
    for (int i = 0; i < 40 && !found; i++) begin
      if (tx_bit === 1'b0) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (tx_bit !== 1'b1) begin fails++; $display("FAIL reset_tx_bit: got %b expected 1", tx_bit); end
    tests++; if (wb_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", wb_ack); end
    tests++; if (wb_data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h expected 00", wb_data_out); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk); reset = 1'b0;
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL reset_status: got %h expected 06", d); end
    wb_read(3'd2, d);
    tests++; if (d !== 8'h4E) begin fails++; $display("FAIL reset_div_lo: got %h expected 4e", d); end
    wb_read(3'd3, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_div_hi: got %h expected 00", d); end
    wb_read(3'd4, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %h expected 00", d); end
  endtask

  task automatic test_bus_handshake();
    logic [7:0] d;
    logic [3:0] exp_ack;
    exp_ack = 4'b0101;
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 3'd5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tests++; if (wb_ack !== exp_ack[k]) begin fails++; $display("FAIL ack_seq_%0d: got %b expected %b", k, wb_ack, exp_ack[k]); end
      if (k == 0) begin
        tests++; if (wb_data_out !== 8'h06) begin fails++; $display("FAIL ack_data: got %h expected 06", wb_data_out); end
      end
    end
    wb_stb = 1'b0;
    @(posedge clk);
    wb_write(3'd4, 8'h1B);
    wb_read(3'd4, d);
    tests++; if (d !== 8'h1B) begin fails++; $display("FAIL ctrl_rw: got %h expected 1b", d); end
    wb_write(3'd4, 8'h00);
    wb_write(3'd7, 8'hFF);
    wb_read(3'd7, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL addr7_read: got %h expected 00", d); end
    wb_read(3'd6, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL addr6_read: got %h expected 00", d); end
    wb_read(3'd1, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL rx_empty_read: got %h expected 00", d); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] d;
    logic [8:0] exp_bits;
    logic       found;
    int         bad;
    exp_bits = {8'hA5, 1'b0};
    wb_write(3'd4, 8'h00);
    set_div(16'd1);
    wb_write(3'd0, 8'hA5);
    wait_tx_fall(found);
    tests++; if (!found) begin fails++; $display("FAIL tx_start_timeout: got no start bit expected one within bound"); end
    for (int k = 0; k < 9; k++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (!(k == 0 && c == 0)) begin @(posedge clk); #1; end
        if (tx_bit !== exp_bits[k]) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL tx_bit_%0d: got %0d wrong cycles expected 0 (level %b)", k, bad, exp_bits[k]); end
    end
    wb_read(3'd5, d);
    tests++; if (d !== 8'h86) begin fails++; $display("FAIL tx_busy_in_stop: got %h expected 86", d); end
    tests++; if (tx_bit !== 1'b1) begin fails++; $display("FAIL tx_stop_level: got %b expected 1", tx_bit); end
    repeat (20) @(posedge clk);
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL tx_busy_after_stop: got %h expected 06", d); end
  endtask

  task automatic test_loopback(input logic [7:0] ctrl, input logic [7:0] data,
                               input logic exp_par);
    logic [7:0] d;
    logic       found;
    loop_en = 1'b1;
    wb_write(3'd4, ctrl);
    wb_write(3'd0, data);
    wait_tx_fall(found);
    tests++; if (!found) begin fails++; $display("FAIL lb_start_timeout: got no start bit expected one within bound"); end
    repeat (152) @(posedge clk);
    #1;
    tests++; if (tx_bit !== exp_par) begin fails++; $display("FAIL lb_parity_bit_ctrl%h: got %b expected %b", ctrl, tx_bit, exp_par); end
    repeat (60) @(posedge clk);
    wb_read(3'd5, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL lb_status_pre_ctrl%h: got %h expected 02", ctrl, d); end
    wb_read(3'd1, d);
    tests++; if (d !== data) begin fails++; $display("FAIL lb_rx_data_ctrl%h: got %h expected %h", ctrl, d, data); end
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL lb_status_post_ctrl%h: got %h expected 06", ctrl, d); end
    loop_en = 1'b0;
  endtask

  task automatic test_parity_err();
    logic [7:0] d;
    wb_write(3'd4, 8'h01);
    send_rx(8'h01, 1'b1, 1'b0, 1'b1);
    wb_read(3'd1, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL par_rx_data: got %h expected 01", d); end
    wb_read(3'd5, d);
    tests++; if (d !== 8'h26) begin fails++; $display("FAIL par_err_set: got %h expected 26", d); end
    wb_write(3'd5, 8'h20);
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL par_err_clear: got %h expected 06", d); end
    wb_write(3'd4, 8'h00);
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    wb_read(3'd1, d);
    tests++; if (d !== 8'h55) begin fails++; $display("FAIL frame_rx_data: got %h expected 55", d); end
    wb_read(3'd5, d);
    tests++; if (d !== 8'h16) begin fails++; $display("FAIL frame_err_set: got %h expected 16", d); end
    wb_write(3'd5, 8'h10);
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL frame_err_clear: got %h expected 06", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i <= FIFO_DEPTH; i++) send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    wb_read(3'd5, d);
    tests++; if (d !== 8'h4A) begin fails++; $display("FAIL ovr_status: got %h expected 4a", d); end
    wb_write(3'd4, 8'h08);
    #1;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL ovr_irq_rx: got %b expected 1", irq); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      wb_read(3'd1, d);
      tests++; if (d !== 8'h10 + 8'(i)) begin fails++; $display("FAIL ovr_byte_%0d: got %h expected %h", i, d, 8'h10 + 8'(i)); end
    end
    wb_read(3'd1, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL ovr_extra_byte: got %h expected 00", d); end
    #1;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL ovr_irq_drained: got %b expected 0", irq); end
    wb_read(3'd5, d);
    tests++; if (d !== 8'h46) begin fails++; $display("FAIL ovr_sticky: got %h expected 46", d); end
    wb_write(3'd5, 8'h40);
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL ovr_clear: got %h expected 06", d); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    int         irq_hi;
    irq_hi = 0;
    wb_write(3'd4, 8'h08);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (irq !== 1'b0) irq_hi++;
    end
    tests++; if (irq_hi != 0) begin fails++; $display("FAIL glitch_irq: got %0d cycles high expected 0", irq_hi); end
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL glitch_status: got %h expected 06", d); end
    wb_write(3'd4, 8'h00);
  endtask

  task automatic test_irq();
    wb_write(3'd4, 8'h10);
    #1;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_tx_empty: got %b expected 1", irq); end
    wb_write(3'd4, 8'h00);
    #1;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b expected 0", irq); end
  endtask

  task automatic test_tx_full_reset();
    logic [7:0] d;
    logic       found;
    set_div(16'h1000);
    wb_read(3'd3, d);
    tests++; if (d !== 8'h10) begin fails++; $display("FAIL div_hi_rw: got %h expected 10", d); end
    for (int i = 0; i < FIFO_DEPTH; i++) wb_write(3'd0, 8'(i));
    wb_read(3'd5, d);
    tests++; if (d !== 8'h05) begin fails++; $display("FAIL tx_full_status: got %h expected 05", d); end
    set_div(16'd1);
    wait_tx_fall(found);
    tests++; if (!found) begin fails++; $display("FAIL rst_start_timeout: got no start bit expected one within bound"); end
    repeat (20) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (tx_bit !== 1'b1) begin fails++; $display("FAIL rst_mid_tx_bit: got %b expected 1", tx_bit); end
    @(negedge clk); reset = 1'b0;
    wb_read(3'd5, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL rst_mid_status: got %h expected 06", d); end
    wb_read(3'd2, d);
    tests++; if (d !== 8'h4E) begin fails++; $display("FAIL rst_mid_div_lo: got %h expected 4e", d); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_bus_handshake();
    test_tx_frame();
    test_loopback(8'h05, 8'h3C, 1'b0);   // even parity, two stop bits, div 1
    set_div(16'd0);                      // divider 0 must behave as 1
    test_loopback(8'h02, 8'h3C, 1'b1);   // odd parity, one stop bit
    set_div(16'd1);
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_irq();
    test_tx_full_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
